register_file_mp: RTL and testbench
===================================

# register_file_mp

Multi-ported successor to the core's single-write, dual-read register file. It has a parametrised number of read and write ports, an optional hard-wired zero register, and a built-in clear sequencer that zeroes every register after reset or on request. Optional write-to-read bypass is compiled in by macro. It sits between decode (read addresses), writeback (write ports) and the hazard unit (`ready`).

## Interface
- `DataWidth`, 16, register width in bits
- `NumRegs`, 16, register count; power of two, ≥2
- `NumReadPorts`, 2, combinational read ports
- `NumWritePorts`, 2, synchronous write ports
- `ZeroReg`, 0, 1 = register 0 reads 0 and ignores writes
- `AddrWidth`, `$clog2(NumRegs)`, derived; not to be overridden

Ports:
- `clk`  in  1  single clock; everything on posedge
- `rst`  in  1  synchronous, active-high reset
- `w_en`  in  `[NumWritePorts]`  per-port write enable
- `w_addr`  in  `[NumWritePorts][AddrWidth]`  write address
- `w_data`  in  `[NumWritePorts][DataWidth]`  write data
- `r_addr`  in  `[NumReadPorts][AddrWidth]`  read address
- `r_data`  out  `[NumReadPorts][DataWidth]`  read data, combinational
- `clear_req`  in  1  one-cycle pulse; starts a full clear sequence
- `ready`  out  1  registered; 1 = file usable

## Operation
- FSM has two states, CLEAR and IDLE, plus counter `clr_idx[AddrWidth]`.
- `rst`=1 at an edge: state←CLEAR, `clr_idx`←0, `ready`←0. The array is not touched on that edge.
- In CLEAR, each edge with `rst`=0 does three things: regs[`clr_idx`]←0, `clr_idx`++, and on the edge where `clr_idx`==NumRegs-1, state←IDLE and `ready`←1.
- In IDLE, `clear_req`=1 at an edge: state←CLEAR, `clr_idx`←0, `ready`←0. Writes presented on that same edge are still performed.
- In CLEAR, `clear_req` is ignored. `rst` mid-clear restarts the sequence at index 0.
- Writes are accepted only when `ready`=1 at the edge. For each port p with `w_en[p]`=1, regs[`w_addr[p]`]←`w_data[p]`.
- Same-address writes on the same edge: the highest-indexed port wins.
- `ZeroReg`=1: writes to address 0 are dropped and `r_data` for address 0 is always 0.
- Reads: while `ready`=0, all `r_data`=0. Otherwise `r_data[i]`=regs[`r_addr[i]`].
- Reset values: `ready`=0; all `r_data`=0, since they are forced while not ready. Array contents are undefined until the clear completes.

## Timing
- Read latency is 0 cycles (combinational from `r_addr`). Write latency is 1 edge.
- Clear duration: `ready` rises exactly NumRegs edges after the first edge with `rst`=0. For example, NumRegs=16 gives 16 edges.
- `clear_req` → `ready`=0 on the next edge → `ready`=1 NumRegs edges later.
- There is no back-pressure on writes. The producer must hold off while `ready`=0; dropped writes are not flagged.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When `ready`=1 and any `w_en[p]` with `w_addr[p]`==`r_addr[i]`, `r_data[i]`=`w_data[p]` in the same cycle.
  - If several ports match, the highest p wins.
  - `ZeroReg` still overrides bypass for address 0.
- `REGFILE_BYPASS_EN` undefined: `r_data` shows the pre-write contents until the edge.

## Structure
- Package `regfile_pkg` holds:
  - `regfile_state_e` {CLEAR, IDLE}
  - default width/count localparams
  - function `regfile_pick_writer` (highest matching port index)
- Sub-module `regfile_clear_seq` holds the FSM, `clr_idx` and `ready`. It outputs `clr_we`/`clr_addr` to the array.
- The top level holds the array, write-priority logic and read muxes.

## Test plan
- Reset/clear: reset, then release. Expect `ready`=0 for 16 edges, then 1, and every read returns 0x0000.
- Dual write, distinct addresses: port0 writes r3←0x1234 and port1 writes r7←0xBEEF on the same edge. Next cycle, reads of r3 and r7 return 0x1234 and 0xBEEF.
- Write conflict: port0 writes r5←0x1111 and port1 writes r5←0x2222 on the same edge. Next cycle, r5=0x2222.
- Zero register: with `ZeroReg`=1, write r0←0xFFFF. r0 reads 0x0000, including in the write cycle when bypass is on.
- Bypass: write r9←0xA5A5 while reading r9 in the same cycle. With `REGFILE_BYPASS_EN`, `r_data`=0xA5A5 that cycle; without it, the old value is returned. Both builds read 0xA5A5 on the next cycle.
- Mid-operation clear: fill r1–r15, then pulse `clear_req` together with a write r2←0x7777.
  - `ready` drops on the next edge.
  - A write attempted during CLEAR is dropped.
  - `rst` asserted after 8 clear edges restarts the count, so `ready` returns 16 edges after `rst` release.
  - Afterwards, all registers read 0x0000.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the write-port priority helper for the register file.
// Latency: none (types and a pure combinational function only).
// Backpressure: not applicable.
package regfile_pkg;

    // Clear sequencer states: CLEAR walks every index writing zero, IDLE means the file is usable.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } regfile_state_e;

    // Default geometry of the file.
    localparam int RegfileDataWidthDef     = 16;
    localparam int RegfileNumRegsDef       = 16;
    localparam int RegfileNumReadPortsDef  = 2;
    localparam int RegfileNumWritePortsDef = 2;

    // Widest port-match vector the priority helper accepts; NumWritePorts must not exceed it.
    localparam int RegfileMaxPorts = 8;

    // Returns the highest port index whose match bit is set, or -1 when no port matches.
    // Highest index wins so that later writeback ports override earlier ones.
    function automatic int regfile_pick_writer(input logic [RegfileMaxPorts-1:0] hit);
        int idx;
        idx = -1;
        for (int p = 0; p < RegfileMaxPorts; p++) begin
            if (hit[p]) begin
                idx = p;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: after reset or a clear request, zeroes one register per edge, then raises ready.
// Latency: ready rises NumRegs edges after the first edge without reset (or after the request edge).
// Backpressure: none; clear requests arriving while already clearing are ignored.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NumRegs   = RegfileNumRegsDef,
    parameter int AddrWidth = $clog2(NumRegs)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_req_i,
    output logic                 ready_o,
    output logic                 clr_we_o,
    output logic [AddrWidth-1:0] clr_addr_o
);

    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumRegs - 1);

    regfile_state_e       state_q;
    logic [AddrWidth-1:0] clr_idx_q;
    logic [AddrWidth-1:0] clr_idx_d;
    logic                 ready_q;

    assign clr_idx_d = clr_idx_q + AddrWidth'(1);

    // Sequencer FSM: reset or request restarts the walk at index 0; ready is set on the last index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_d;
                    if (clr_idx_q == LastIdx) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req_i) begin
                        state_q   <= CLEAR;
                        clr_idx_q <= '0;
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_idx_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // The array is left untouched on a reset edge, so the zeroing strobe is masked by reset.
    assign clr_we_o   = (state_q == CLEAR) && !rst_i;
    assign clr_addr_o = clr_idx_q;
    assign ready_o    = ready_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with built-in clear sequencer; optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN.
// Latency: reads combinational (0 cycles), writes land on the next edge; clear takes NumRegs edges.
// Backpressure: none; writes presented while ready is low are silently dropped.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DataWidth     = RegfileDataWidthDef,
    parameter int NumRegs       = RegfileNumRegsDef,
    parameter int NumReadPorts  = RegfileNumReadPortsDef,
    parameter int NumWritePorts = RegfileNumWritePortsDef,
    parameter int ZeroReg       = 0,
    parameter int AddrWidth     = $clog2(NumRegs)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NumWritePorts-1:0]                w_en,
    input  logic [NumWritePorts-1:0][AddrWidth-1:0] w_addr,
    input  logic [NumWritePorts-1:0][DataWidth-1:0] w_data,
    input  logic [NumReadPorts-1:0][AddrWidth-1:0]  r_addr,
    output logic [NumReadPorts-1:0][DataWidth-1:0]  r_data,
    input  logic                                    clear_req,
    output logic                                    ready
);

    logic                 clr_we;
    logic [AddrWidth-1:0] clr_addr;

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];

    logic [RegfileMaxPorts-1:0] wr_hit;
    int                         wr_sel;

    regfile_clear_seq #(
        .NumRegs   (NumRegs),
        .AddrWidth (AddrWidth)
    ) u_clear_seq (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_req_i (clear_req),
        .ready_o     (ready),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    // Next array contents: clear strobe, then per-register write with highest matching port winning.
    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        wr_sel = -1;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end
        // The request edge still has ready high, so writes on that edge are kept.
        if (ready && !rst) begin
            for (int r = 0; r < NumRegs; r++) begin
                if (!((ZeroReg != 0) && (r == 0))) begin
                    wr_hit = '0;
                    for (int p = 0; p < NumWritePorts; p++) begin
                        wr_hit[p] = w_en[p] && (w_addr[p] == AddrWidth'(r));
                    end
                    wr_sel = regfile_pick_writer(wr_hit);
                    for (int p = 0; p < NumWritePorts; p++) begin
                        if (wr_sel == p) begin
                            regs_d[r] = w_data[p];
                        end
                    end
                end
            end
        end
    end

    // Storage has no reset; the clear sequencer defines its contents before ready rises.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

`ifdef REGFILE_BYPASS_EN
    logic [RegfileMaxPorts-1:0] byp_hit;
    int                         byp_sel;
`endif

    // Read muxes: forced to zero while not ready, optional bypass, zero register overrides all.
    always_comb begin
        r_data = '0;
`ifdef REGFILE_BYPASS_EN
        byp_hit = '0;
        byp_sel = -1;
`endif
        for (int i = 0; i < NumReadPorts; i++) begin
            if (ready) begin
                r_data[i] = regs_q[r_addr[i]];
`ifdef REGFILE_BYPASS_EN
                byp_hit = '0;
                for (int p = 0; p < NumWritePorts; p++) begin
                    byp_hit[p] = w_en[p] && (w_addr[p] == r_addr[i]);
                end
                byp_sel = regfile_pick_writer(byp_hit);
                for (int p = 0; p < NumWritePorts; p++) begin
                    if (byp_sel == p) begin
                        r_data[i] = w_data[p];
                    end
                end
`endif
                if ((ZeroReg != 0) && (r_addr[i] == '0)) begin
                    r_data[i] = '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (ZeroReg=1, 16 x 16-bit, 2R/2W).
// Expected read data is queued when a read is set up and popped when the outputs are sampled.
// Adapts same-cycle bypass expectations to whether REGFILE_BYPASS_EN is defined.
module tb_register_file_mp;

    localparam int DW  = 16;
    localparam int NR  = 16;
    localparam int NRP = 2;
    localparam int NWP = 2;
    localparam int AW  = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     clear_req = 1'b0;
    logic                     ready;
    logic [NWP-1:0]           w_en;
    logic [NWP-1:0][AW-1:0]   w_addr;
    logic [NWP-1:0][DW-1:0]   w_data;
    logic [NRP-1:0][AW-1:0]   r_addr;
    logic [NRP-1:0][DW-1:0]   r_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model [NR];
    bit            mready = 1'b0;
    logic [DW-1:0] sb [$];

    register_file_mp #(
        .DataWidth     (DW),
        .NumRegs       (NR),
        .NumReadPorts  (NRP),
        .NumWritePorts (NWP),
        .ZeroReg       (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .clear_req (clear_req),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (!mready || a == '0) return '0;
        return model[a];
    endfunction

    // Present two read addresses, queue expectations, then sample and compare.
    task automatic sb_read(input string tag, input logic [AW-1:0] a0, input logic [DW-1:0] e0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] e1);
        logic [DW-1:0] e;
        r_addr[0] = a0;
        r_addr[1] = a1;
        sb.push_back(e0);
        sb.push_back(e1);
        #2;
        for (int i = 0; i < NRP; i++) begin
            e = sb.pop_front();
            check(tag, 32'(r_data[i]), 32'(e));
        end
    endtask

    task automatic read2(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        sb_read(tag, a0, model_rd(a0), a1, model_rd(a1));
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < NR; a += 2) begin
            read2(tag, AW'(a), AW'(a + 1));
        end
    endtask

    task automatic drive_wr(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        w_en[0] = e0; w_addr[0] = a0; w_data[0] = d0;
        w_en[1] = e1; w_addr[1] = a1; w_data[1] = d1;
    endtask

    // One clock edge: reference model absorbs whatever the bench drove, then inputs drop.
    task automatic commit();
        @(posedge clk);
        if (rst) begin
            mready = 1'b0;
        end else if (mready) begin
            for (int p = 0; p < NWP; p++) begin
                if (w_en[p] && w_addr[p] != '0) model[w_addr[p]] = w_data[p];
            end
            if (clear_req) mready = 1'b0;
        end
        #1;
        w_en = '0;
        clear_req = 1'b0;
    endtask

    task automatic wr2(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        drive_wr(e0, a0, d0, e1, a1, d1);
        commit();
    endtask

    // Count edges until ready rises (bounded), compare with the expected count.
    task automatic wait_ready(input string tag, input int exp_edges);
        int k;
        k = 0;
        while (k < 64) begin
            commit();
            k++;
            if (ready) break;
        end
        check(tag, 32'(k), 32'(exp_edges));
        if (ready) begin
            mready = 1'b1;
            for (int r = 0; r < NR; r++) model[r] = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        w_en   = '0;
        w_addr = '0;
        w_data = '0;
        r_addr = '0;
        for (int r = 0; r < NR; r++) model[r] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        read2("rst_rd", 4'd3, 4'd7);
        rst = 1'b0;
        wait_ready("rst_clr_len", NR);
        read_all("clr_rd");

        // Dual write, distinct addresses
        wr2(1'b1, 4'd3, 16'h1234, 1'b1, 4'd7, 16'hBEEF);
        read2("dual_wr", 4'd3, 4'd7);

        // Same-address conflict: port 1 wins
        wr2(1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222);
        read2("conflict", 4'd5, 4'd5);

        // Zero register ignores writes, including the write cycle
        drive_wr(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0000);
        sb_read("zero_same", 4'd0, 16'h0000, 4'd0, 16'h0000);
        commit();
        read2("zero_after", 4'd0, 4'd0);

        // Bypass on a single writer
        drive_wr(1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 16'hA5A5);
        sb_read("byp_same", 4'd9, Byp ? 16'hA5A5 : model_rd(4'd9), 4'd3, model_rd(4'd3));
        commit();
        read2("byp_next", 4'd9, 4'd3);

        // Bypass with both ports on one address
        drive_wr(1'b1, 4'd10, 16'hAAAA, 1'b1, 4'd10, 16'hBBBB);
        sb_read("byp_prio", 4'd10, Byp ? 16'hBBBB : model_rd(4'd10),
                4'd10, Byp ? 16'hBBBB : model_rd(4'd10));
        commit();
        read2("byp_prio_next", 4'd10, 4'd10);

        // Fill r1..r15, alternating ports
        for (int a = 1; a < NR; a++) begin
            wr2(a % 2 == 0, AW'(a), DW'(a * 16'h0911 + 16'h0101),
                a % 2 == 1, AW'(a), DW'(a * 16'h0911 + 16'h0101));
        end
        read_all("fill");

        // Clear request with a same-edge write
        clear_req = 1'b1;
        drive_wr(1'b1, 4'd2, 16'h7777, 1'b0, 4'd0, 16'h0000);
        commit();
        check("clrq_drop", 32'(ready), 32'd0);
        read2("clrq_rd", 4'd2, 4'd15);
        repeat (4) commit();
        // Write to an already-cleared index and a redundant request while clearing
        clear_req = 1'b1;
        drive_wr(1'b1, 4'd1, 16'h1357, 1'b0, 4'd0, 16'h0000);
        commit();
        check("clr_busy", 32'(ready), 32'd0);
        wait_ready("clrq_len", NR - 5);
        read_all("clrq_after");

        // Reset in the middle of a clear restarts the walk
        wr2(1'b1, 4'd6, 16'h6666, 1'b0, 4'd0, 16'h0000);
        read2("pre_rst_mid", 4'd6, 4'd6);
        clear_req = 1'b1;
        commit();
        repeat (8) commit();
        rst = 1'b1;
        commit();
        check("rst_mid", 32'(ready), 32'd0);
        rst = 1'b0;
        wait_ready("rst_mid_len", NR);
        read_all("rst_mid_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
